// File: rtl/fpu_unpack_pkg.sv
// rtl/fpu_unpack_pkg.sv - shared flag indices, opcodes and bundle types for the unpack skid stage
package fpu_unpack_pkg;

    localparam int FL_ZERO = 3;
    localparam int FL_INF  = 2;
    localparam int FL_SNAN = 1;
    localparam int FL_NAN  = 0;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int DEF_EXP_W  = 11;
    localparam int DEF_FRAC_W = 53;
    localparam int LZ_W       = 6;
    localparam int FL_W       = 4;

    typedef struct packed {
        logic sr;
        logic spec;
        logic inv;
        logic dbz;
    } cls_t;

    // Bundle layout at the default double-precision widths.
    typedef struct packed {
        logic                  op;
        logic                  sa;
        logic                  sb;
        logic [DEF_EXP_W-1:0]  ea;
        logic [DEF_EXP_W-1:0]  eb;
        logic [LZ_W-1:0]       lza;
        logic [LZ_W-1:0]       lzb;
        logic [DEF_FRAC_W-1:0] fa;
        logic [DEF_FRAC_W-1:0] fb;
        logic [FL_W-1:0]       fla;
        logic [FL_W-1:0]       flb;
        logic [DEF_FRAC_W-1:0] nan;
        cls_t                  cls;
    } unpk_bundle_t;

endpackage

// File: rtl/unpack_special_cls.sv
// rtl/unpack_special_cls.sv - combinational special-case classification of a mul/div operand pair
module unpack_special_cls
    import fpu_unpack_pkg::*;
(
    input  logic            op,
    input  logic            sa,
    input  logic            sb,
    input  logic [FL_W-1:0] fla,
    input  logic [FL_W-1:0] flb,
    output cls_t            cls
);

    logic inv_mul, inv_div, dbz, inv, any_special;

    always_comb begin
        inv_mul = (fla[FL_INF] & flb[FL_ZERO]) | (fla[FL_ZERO] & flb[FL_INF]);
        inv_div = (fla[FL_ZERO] & flb[FL_ZERO]) | (fla[FL_INF] & flb[FL_INF]);
        inv     = fla[FL_SNAN] | flb[FL_SNAN] |
                  ((op == OP_MUL) & inv_mul) | ((op == OP_DIV) & inv_div);
        // Only a finite non-zero dividend divided by zero is a divide-by-zero.
        dbz     = (op == OP_DIV) & flb[FL_ZERO] &
                  ~(fla[FL_ZERO] | fla[FL_INF] | fla[FL_NAN]);
        any_special = fla[FL_ZERO] | fla[FL_INF] | fla[FL_NAN] |
                      flb[FL_ZERO] | flb[FL_INF] | flb[FL_NAN];
        cls.sr   = sa ^ sb;
        cls.inv  = inv;
        cls.dbz  = dbz;
        cls.spec = inv | dbz | any_special;
    end

endmodule

// File: rtl/unpack_skid_stage.sv
// rtl/unpack_skid_stage.sv - two-entry skid register between unpacker and mul/div core; UNPK_STALL_CNT_EN adds stall_cnt
module unpack_skid_stage
    import fpu_unpack_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 53
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
    input  logic              in_sa,
    input  logic              in_sb,
    input  logic [EXP_W-1:0]  in_ea,
    input  logic [EXP_W-1:0]  in_eb,
    input  logic [5:0]        in_lza,
    input  logic [5:0]        in_lzb,
    input  logic [FRAC_W-1:0] in_fa,
    input  logic [FRAC_W-1:0] in_fb,
    input  logic [3:0]        in_fla,
    input  logic [3:0]        in_flb,
    input  logic [FRAC_W-1:0] in_nan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_op,
    output logic              out_sa,
    output logic              out_sb,
    output logic [EXP_W-1:0]  out_ea,
    output logic [EXP_W-1:0]  out_eb,
    output logic [5:0]        out_lza,
    output logic [5:0]        out_lzb,
    output logic [FRAC_W-1:0] out_fa,
    output logic [FRAC_W-1:0] out_fb,
    output logic [3:0]        out_fla,
    output logic [3:0]        out_flb,
    output logic [FRAC_W-1:0] out_nan,
    output logic              out_sr,
    output logic              out_spec,
    output logic              out_inv,
    output logic              out_dbz
`ifdef UNPK_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic              op;
        logic              sa;
        logic              sb;
        logic [EXP_W-1:0]  ea;
        logic [EXP_W-1:0]  eb;
        logic [LZ_W-1:0]   lza;
        logic [LZ_W-1:0]   lzb;
        logic [FRAC_W-1:0] fa;
        logic [FRAC_W-1:0] fb;
        logic [FL_W-1:0]   fla;
        logic [FL_W-1:0]   flb;
        logic [FRAC_W-1:0] nan;
        cls_t              cls;
    } entry_t;

    cls_t   in_cls;
    entry_t in_ent, main_q, skid_q;
    logic   main_v, skid_v, accept, skid_next;

    unpack_special_cls u_cls (
        .op  (op),
        .sa  (in_sa),
        .sb  (in_sb),
        .fla (in_fla),
        .flb (in_flb),
        .cls (in_cls)
    );

    always_comb begin
        in_ent = '{op: op, sa: in_sa, sb: in_sb, ea: in_ea, eb: in_eb,
                   lza: in_lza, lzb: in_lzb, fa: in_fa, fb: in_fb,
                   fla: in_fla, flb: in_flb, nan: in_nan, cls: in_cls};
        accept = in_valid & in_ready;
        // in_ready is the registered inverse of the skid occupancy one cycle ahead.
        skid_next = skid_v ? ~out_ready : (accept & main_v & ~out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (skid_v) begin
                if (out_ready) begin
                    main_q <= skid_q;
                    skid_v <= 1'b0;
                end
            end else if (accept) begin
                if (!main_v || out_ready) begin
                    main_q <= in_ent;
                    main_v <= 1'b1;
                end else begin
                    skid_q <= in_ent;
                    skid_v <= 1'b1;
                end
            end else if (out_ready) begin
                main_v <= 1'b0;
            end
            in_ready <= ~skid_next;
        end
    end

    assign out_valid = main_v;
    assign out_op    = main_q.op;
    assign out_sa    = main_q.sa;
    assign out_sb    = main_q.sb;
    assign out_ea    = main_q.ea;
    assign out_eb    = main_q.eb;
    assign out_lza   = main_q.lza;
    assign out_lzb   = main_q.lzb;
    assign out_fa    = main_q.fa;
    assign out_fb    = main_q.fb;
    assign out_fla   = main_q.fla;
    assign out_flb   = main_q.flb;
    assign out_nan   = main_q.nan;
    assign out_sr    = main_q.cls.sr;
    assign out_spec  = main_q.cls.spec;
    assign out_inv   = main_q.cls.inv;
    assign out_dbz   = main_q.cls.dbz;

`ifdef UNPK_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
